// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D-cache memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FILL_ISSUE = 2'd1,
    FILL_DRAIN = 2'd2,
    WRITE      = 2'd3
  } state_t;

  localparam int          BLOCK_WORDS = 8;
  localparam int          MEM_LATENCY = 4;
  localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module arb_rr_select (
  input  logic i_req,
  input  logic d_req,
  input  logic last_i,
  output logic grant_i,
  output logic grant_d
);

  assign grant_d = d_req & (~i_req | last_i);
  assign grant_i = i_req & (~d_req | ~last_i);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache block fills and D-cache fills/word writes onto one memory port.
module mem_arbiter #(
  parameter int BLOCK_WORDS = mem_arbiter_pkg::BLOCK_WORDS,
  parameter int MEM_LATENCY = mem_arbiter_pkg::MEM_LATENCY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] fill_data,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic [2:0]  fill_idx,
  output logic        i_done,
  output logic        d_done,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid
);
  import mem_arbiter_pkg::*;

  localparam int            CW   = $clog2(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_WORDS - 1);

  // fill_idx is three bits wide, so the block size is pinned to eight words.
  if (BLOCK_WORDS != 8 || MEM_LATENCY < 1) begin : g_param_check
    $error("mem_arbiter: unsupported BLOCK_WORDS/MEM_LATENCY");
  end

  state_t        state, state_nx;
  logic [CW-1:0] issue_cnt, ret_cnt;
  logic          owner_d, last_i;
  logic          grant_i, grant_d;
  logic [15:0]   lat_addr, lat_wdata;
  logic [15:0]   fill_base;
  logic          ret_fire, last_ret, last_issue;

  arb_rr_select u_rr (
    .i_req   (i_req),
    .d_req   (d_req),
    .last_i  (last_i),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  assign fill_base  = lat_addr & BLOCK_MASK;
  assign ret_fire   = mem_data_valid && (state == FILL_ISSUE || state == FILL_DRAIN);
  assign last_ret   = ret_fire && (ret_cnt == LAST);
  assign last_issue = (issue_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      owner_d   <= 1'b0;
      last_i    <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        issue_cnt <= '0;
        ret_cnt   <= '0;
        if (grant_i || grant_d) begin
          owner_d <= grant_d;
          last_i  <= grant_i;
        end
      end else begin
        if (state == FILL_ISSUE) issue_cnt <= issue_cnt + 1'b1;
        if (ret_fire)            ret_cnt   <= ret_cnt + 1'b1;
      end
    end
  end

  // Address/data capture is datapath only; it is qualified by state, not reset.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      lat_addr  <= grant_d ? d_addr : i_addr;
      lat_wdata <= d_wdata;
    end
  end

  always_comb begin
    state_nx    = state;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    i_done      = 1'b0;
    d_done      = 1'b0;
    fill_data   = ret_fire ? mem_data_out : '0;
    fill_idx    = ret_fire ? 3'(ret_cnt) : '0;
    i_fill_we   = ret_fire & ~owner_d;
    d_fill_we   = ret_fire & owner_d;

    case (state)
      IDLE: begin
        if (grant_d)      state_nx = d_wr ? WRITE : FILL_ISSUE;
        else if (grant_i) state_nx = FILL_ISSUE;
      end
      FILL_ISSUE: begin
        mem_enable = 1'b1;
        mem_addr   = fill_base + 16'({issue_cnt, 1'b0});
        if (last_issue) state_nx = FILL_DRAIN;
      end
      FILL_DRAIN: ;
      WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = lat_addr & 16'hFFFE;
        mem_data_in = lat_wdata;
        d_done      = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // The final return closes the fill regardless of where issuing stands.
    if (last_ret) begin
      i_done   = ~owner_d;
      d_done   = owner_d;
      state_nx = IDLE;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a 4-cycle pipelined memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] fill_data, mem_addr, mem_data_in, mem_data_out;
  logic        i_fill_we, d_fill_we, i_done, d_done;
  logic        mem_enable, mem_wr, mem_data_valid;
  logic [2:0]  fill_idx;

  logic        preload;
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [3:0]  pv = '0;
  logic [15:0] pd [0:3];
  logic [19:0] sbq [$];
  int          n_vec  = 0;
  int          n_miss = 0;

  mem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .d_req          (d_req),
    .d_wr           (d_wr),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .fill_data      (fill_data),
    .i_fill_we      (i_fill_we),
    .d_fill_we      (d_fill_we),
    .fill_idx       (fill_idx),
    .i_done         (i_done),
    .d_done         (d_done),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_data_valid (mem_data_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] image(input logic [15:0] a);
    if (a >= 16'h0040 && a <= 16'h004F) return 16'hA000 + 16'((a - 16'h0040) >> 1);
    if (a >= 16'hFFF0)                  return 16'hC000 + 16'((a - 16'hFFF0) >> 1);
    return 16'h0000;
  endfunction

  // Memory: reads return MEM_LATENCY=4 cycles after issue; writes land at the edge.
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 65536; a++) mem[a] <= image(16'(a));
    end else if (mem_enable && mem_wr) begin
      mem[mem_addr] <= mem_data_in;
    end
    pv    <= {pv[2:0], mem_enable & ~mem_wr};
    pd[0] <= mem[mem_addr];
    for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
  end

  assign mem_data_valid = pv[3];
  assign mem_data_out   = pd[3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (i_fill_we || d_fill_we) begin
      if (sbq.size() == 0) begin
        chk("fill_unexpected", 64'(i_fill_we | d_fill_we), 64'd0);
      end else begin
        chk("fill_word", {d_fill_we, fill_idx, fill_data}, sbq.pop_front());
      end
    end
  end

  function automatic logic [56:0] all_out();
    return {fill_data, i_fill_we, d_fill_we, fill_idx, i_done, d_done,
            mem_enable, mem_wr, mem_addr, mem_data_in};
  endfunction

  // Entered #1 into the IDLE cycle where the owner's request is first seen;
  // returns #1 into the cycle after done.
  task automatic watch_fill(input bit is_d, input logic [15:0] base);
    for (int k = 0; k < 8; k++)
      sbq.push_back({is_d, 3'(k), ref_mem[16'(base + 16'(2 * k))]});
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      chk("mem_enable", mem_enable, 64'(c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) begin
        chk("mem_addr", mem_addr, 64'(16'(base + 16'(2 * (c - 1)))));
        chk("mem_wr", mem_wr, 64'd0);
      end
      chk("owner_we", is_d ? d_fill_we : i_fill_we, 64'(c >= 5 && c <= 12));
      chk("other_we", is_d ? i_fill_we : d_fill_we, 64'd0);
      chk("owner_done", is_d ? d_done : i_done, 64'(c == 12));
      chk("other_done", is_d ? i_done : d_done, 64'd0);
      if (c == 12) begin
        if (is_d) d_req = 1'b0;
        else      i_req = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    for (int a = 0; a < 65536; a++) ref_mem[a] = image(16'(a));
    @(posedge clk); #1 preload = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_outs", all_out(), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // I-cache fill of the block holding 0x004A
    i_req = 1'b1; i_addr = 16'h004A;
    watch_fill(1'b0, 16'h0040);

    // D word write, then an I fill that must see the new word at index 1
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0043; d_wdata = 16'hBEEF;
    ref_mem[16'h0042] = 16'hBEEF;
    @(negedge clk);
    chk("wr_idle", mem_enable, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_cmd", {mem_enable, mem_wr, mem_addr, mem_data_in, d_done}, {1'b1, 1'b1, 16'h0042, 16'hBEEF, 1'b1});
    chk("wr_quiet", {i_done, i_fill_we, d_fill_we}, 64'd0);
    d_req = 1'b0; d_wr = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_after", {mem_enable, d_done}, 64'd0);
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 16'h004A;
    watch_fill(1'b0, 16'h0040);

    // Simultaneous requests straight out of reset: D first, then I
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0044;
    i_req = 1'b1; i_addr = 16'h0041;
    watch_fill(1'b1, 16'h0040);
    watch_fill(1'b0, 16'h0040);

    // Top-of-memory block must not wrap to 0x0000
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'hFFF6;
    watch_fill(1'b1, 16'hFFF0);

    // Reset at cycle 7 of a fill: quiet outputs, stale returns ignored
    i_req = 1'b1; i_addr = 16'h0040;
    for (int k = 0; k < 3; k++) sbq.push_back({1'b0, 3'(k), ref_mem[16'(16'h0040 + 16'(2 * k))]});
    for (int c = 0; c <= 14; c++) begin
      if (c == 7)  begin rst_n = 1'b0; i_req = 1'b0; end
      if (c == 10) rst_n = 1'b1;
      @(negedge clk);
      if (c >= 8) chk("rst_quiet", all_out(), 64'd0);
      @(posedge clk); #1;
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BLOCK_WORDS, default 8: 16-bit words per cache-block fill.
REQ-002 Parameter MEM_LATENCY, default 4: cycles from read issue to mem_data_valid.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_req / i_addr  in  1 / 16  I-cache fill request, held until i_done; miss address.
REQ-006 d_req / d_wr / d_addr / d_wdata  in  1/1/16/16  D-cache request, held until d_done; d_wr=1 means word write, 0 means block fill.
REQ-007 fill_data  out  16  returned word, shared by both requesters.
REQ-008 i_fill_we / d_fill_we  out  1  fill_data valid for that requester this cycle.
REQ-009 fill_idx  out  3  word index within block of current fill_data.
REQ-010 i_done / d_done  out  1  one-cycle transaction-complete pulse.
REQ-011 mem_enable / mem_wr / mem_addr / mem_data_in  out  1/1/16/16  memory command.
REQ-012 mem_data_out / mem_data_valid  in  16/1  memory read return.

Function
REQ-013 States IDLE, FILL_ISSUE, FILL_DRAIN, WRITE; one transaction in flight at a time.
REQ-014 IDLE: no memory command; samples requests, latches owner, base address and write data; next state per request.
REQ-015 Arbitration is round-robin: both requesting, grant goes to requester not served last; after reset D is preferred.
REQ-016 Fill base = addr & 16'hFFF0; word k issued at base + 2k; mem_addr bit 0 always 0.
REQ-017 FILL_ISSUE: mem_enable=1, mem_wr=0, one word per cycle for BLOCK_WORDS consecutive cycles, k = 0..7; then FILL_DRAIN.
REQ-018 Every mem_data_valid during FILL_ISSUE/FILL_DRAIN: fill_data=mem_data_out, owner fill_we=1, fill_idx=return count, count increments.
REQ-019 On 8th valid: owner done=1 same cycle; next state IDLE.
REQ-020 Fill timing: request seen in IDLE cycle 0 -> issues cycles 1-8 -> fill_we cycles 5-12 -> done cycle 12 -> IDLE cycle 13.
REQ-021 WRITE (D only, d_wr=1): one cycle with mem_enable=1, mem_wr=1, mem_addr=latched d_addr with bit 0 cleared, mem_data_in=latched d_wdata; d_done=1 that cycle; next IDLE.
REQ-022 Requests dropped mid-transaction are ignored; transaction runs to completion.
REQ-023 mem_data_valid in IDLE or WRITE is ignored; no fill_we, no done.
REQ-024 Address wrap: base 16'hFFF0 last word 16'hFFFE; no carry beyond 16 bits.
REQ-025 Requester still asserting req in the cycle after done is treated as a new request (back-to-back allowed).
REQ-026 All outputs are 0 whenever no command/return is active.

Reset
REQ-027 rst_n=0 at an edge: state IDLE, counters 0, last-served = I (D preferred), all outputs 0 next cycle.
REQ-028 Reset mid-fill abandons fill; no done issued; in-flight returns after reset are ignored per REQ-023.

Structure
REQ-029 Shared package holds state enum, BLOCK_WORDS, MEM_LATENCY, BLOCK_MASK 16'hFFF0.
REQ-030 Optional sub-module arb_rr_select (two requests, last-served bit -> grant); everything else in mem_arbiter.

Verification
REQ-031 Bench uses the 4-cycle memory model, preloaded mem[16'h0040 + 2k] = 16'hA000 + k.
REQ-032 i_req, i_addr=16'h004A -> i_fill_we cycles 5-12, fill_data 16'hA000..A007, fill_idx 0..7, i_done cycle 12 only.
REQ-033 d_req, d_wr=1, d_addr=16'h0043, d_wdata=16'hBEEF -> cycle 1 mem_wr=1, mem_addr=16'h0042, d_done=1; later I fill returns 16'hBEEF at idx 1.
REQ-034 i_req and d_req (fill) together from reset -> D served first; I issue begins cycle 14; I fill completes.
REQ-035 d_addr=16'hFFF6 fill -> mem_addr 16'hFFF0..16'hFFFE; no wrap to 16'h0000.
REQ-036 rst_n low at cycle 7 of fill -> all outputs 0 next cycle; no fill_we or done from stale returns.
